instruction_fetch_stage: RTL and testbench

//   Initiator side of the instruction-memory read interface: owns the PC, drives the

---
 rtl/instruction_fetch_stage.sv | 116 +++++++++++
 tb/tb_instruction_fetch_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage
//   Front of the pipeline. It holds the program counter and presents it as the
//   word address to a combinational instruction memory. The returned word is
//   captured into the IF/ID register. A decode-side freeze holds the whole stage.
//   An EX-side branch redirects the PC and flushes the wrong-path fetch.
//   Edge priority: rst > branch_taken > freeze > normal advance.
//   Optional feature macro: FETCH_PERF_CNT_EN adds the fetched and flushed event counters.
module instruction_fetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [31:0]       if_id_instr,
  output logic              if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
`endif
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
  logic [31:0]       if_id_instr_q, if_id_instr_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic              advance;

  // Sequential PC. The addition wraps silently at the top of the address space.
  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign advance  = !branch_taken && !freeze;

  // Next-state selection for the PC and the IF/ID register: redirect, hold or advance.
  always_comb begin
    // NOTE: every signal gets a hold default up front, so each path through
    // the if/else assigns it and no latch can be inferred.
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    if (branch_taken) begin
      // Masking keeps the target word-aligned. This drops the low bits of a misaligned target.
      pc_d          = branch_addr & ~ADDR_W'(3);
      if_id_pc_d    = '0;
      if_id_instr_d = '0;
      if_id_valid_d = 1'b0;
    end else if (!freeze) begin
      pc_d          = pc_plus4;
      if_id_pc_d    = pc_plus4;
      if_id_instr_d = imem_instr;
      if_id_valid_d = 1'b1;
    end
  end

  // State registers with synchronous reset that overrides every other input.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here let all flops sample their _d values
    // from the same pre-edge state, independent of statement order.
    if (rst) begin
      pc_q          <= RESET_PC;
      if_id_pc_q    <= '0;
      if_id_instr_q <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;

  // Event counters: fetched counts normal advances and flushed counts redirects. Both hold during freeze.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_flushed_d = perf_flushed_q;
    if (branch_taken) perf_flushed_d = perf_flushed_q + 32'd1;
    else if (advance) perf_fetched_d = perf_fetched_q + 32'd1;
  end

  // Counter registers. They clear on reset and wrap modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`else
  // Without the counters, "advance" only documents the normal-advance
  // condition. This assignment references it so that it is not left dangling.
  logic advance_unused;
  assign advance_unused = advance;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Testbench for instruction_fetch_stage.
// It drives a table of single-edge vectors with expected post-edge outputs.
// A scoreboard queue checks each vector. Hand-written sequences then cover a long freeze and a long free run.
module tb_instruction_fetch_stage;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst, freeze, branch_taken;
  logic [ADDR_W-1:0] branch_addr;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_instr;
  logic [ADDR_W-1:0] if_id_pc;
  logic [31:0]       if_id_instr;
  logic              if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       perf_fetched, perf_flushed;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  instruction_fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  // Combinational memory: words 0..15 hold 0x20 + 4*index and every other word holds 0.
  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-3:0] idx;
    idx = a[ADDR_W-1:2];
    if (idx < 16) return 32'h20 + (32'(idx) << 2);
    return 32'h0;
  endfunction

  always_comb imem_instr = mem_word(imem_addr);

  typedef struct {
    logic        rst;
    logic        frz;
    logic        br;
    logic [31:0] baddr;
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] instr;
    logic        valid;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] instr;
    logic        valid;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   exp_fetched = 0;
  int   exp_flushed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic b, input logic [31:0] ba,
                     input logic [31:0] pc, input logic [31:0] ifpc,
                     input logic [31:0] ins, input logic v);
    vec_t t;
    t = '{rst: r, frz: f, br: b, baddr: ba, pc: pc, ifpc: ifpc, instr: ins, valid: v};
    vecs.push_back(t);
  endtask

  // Applies one edge's inputs, pushes its expectation, then pops and compares after the edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e, got;
    @(negedge clk);
    rst = v.rst; freeze = v.frz; branch_taken = v.br; branch_addr = v.baddr;
    e = '{pc: v.pc, ifpc: v.ifpc, instr: v.instr, valid: v.valid};
    sb_q.push_back(e);
    if (v.rst) begin
      exp_fetched = 0; exp_flushed = 0;
    end else if (v.br) exp_flushed++;
    else if (!v.frz) exp_fetched++;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check({tag, " imem_addr"},   imem_addr,   got.pc);
      check({tag, " if_id_pc"},    if_id_pc,    got.ifpc);
      check({tag, " if_id_instr"}, if_id_instr, got.instr);
      check({tag, " if_id_valid"}, 32'(if_id_valid), 32'(got.valid));
`ifdef FETCH_PERF_CNT_EN
      check({tag, " perf_fetched"}, perf_fetched, 32'(exp_fetched));
      check({tag, " perf_flushed"}, perf_flushed, 32'(exp_flushed));
`endif
    end
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;

    //   rst frz br  baddr          pc             if_pc          instr          valid
    add(1, 0, 0, 32'h0,          32'h0,          32'h0,          32'h0,  0); // reset edge 1
    add(1, 0, 0, 32'h0,          32'h0,          32'h0,          32'h0,  0); // reset edge 2
    add(0, 0, 0, 32'h0,          32'h4,          32'h4,          32'h20, 1); // first fetch
    add(0, 0, 0, 32'h0,          32'h8,          32'h8,          32'h24, 1);
    add(0, 1, 0, 32'h0,          32'h8,          32'h8,          32'h24, 1); // freeze x3 at pc=8
    add(0, 1, 0, 32'h0,          32'h8,          32'h8,          32'h24, 1);
    add(0, 1, 0, 32'h0,          32'h8,          32'h8,          32'h24, 1);
    add(0, 0, 0, 32'h0,          32'hC,          32'hC,          32'h28, 1); // release
    add(0, 0, 1, 32'h1E,         32'h1C,         32'h0,          32'h0,  0); // branch, low bits dropped
    add(0, 0, 0, 32'h0,          32'h20,         32'h20,         32'h3C, 1); // word7
    add(0, 0, 0, 32'h0,          32'h24,         32'h24,         32'h40, 1);
    add(0, 1, 1, 32'h0,          32'h0,          32'h0,          32'h0,  0); // branch beats freeze
    add(0, 0, 1, 32'h40,         32'h40,         32'h0,          32'h0,  0); // back-to-back branches
    add(0, 0, 1, 32'h13,         32'h10,         32'h0,          32'h0,  0); // last one wins
    add(0, 0, 0, 32'h0,          32'h14,         32'h14,         32'h30, 1);
    add(0, 1, 0, 32'h0,          32'h14,         32'h14,         32'h30, 1);
    add(1, 1, 0, 32'h0,          32'h0,          32'h0,          32'h0,  0); // reset mid-freeze
    add(0, 0, 0, 32'h0,          32'h4,          32'h4,          32'h20, 1);
    add(1, 0, 1, 32'h80,         32'h0,          32'h0,          32'h0,  0); // reset beats branch
    add(0, 0, 1, 32'hFFFF_FFFF,  32'hFFFF_FFFC,  32'h0,          32'h0,  0); // jump to top word
    add(0, 0, 0, 32'h0,          32'h0,          32'h0,          32'h0,  1); // wrap, zero word valid
    add(0, 0, 0, 32'h0,          32'h4,          32'h4,          32'h20, 1);

    foreach (vecs[i]) begin
      v = vecs[i];
      apply(v, $sformatf("vec%0d", i));
    end

    // Hold freeze for a long stretch and check that all outputs and imem_addr stay constant.
    for (int i = 0; i < 20; i++) begin
      v = '{rst: 0, frz: 1, br: 0, baddr: 32'hDEAD_BEEF,
            pc: 32'h4, ifpc: 32'h4, instr: 32'h20, valid: 1};
      apply(v, $sformatf("long_freeze%0d", i));
    end

    // Free run through the populated words and into the zero-filled region.
    for (int i = 0; i < 18; i++) begin
      logic [31:0] pc_before;
      pc_before = 32'h4 + 32'(i) * 4;
      v = '{rst: 0, frz: 0, br: 0, baddr: 32'h0,
            pc: pc_before + 4, ifpc: pc_before + 4,
            instr: (pc_before < 32'h40) ? 32'h20 + pc_before : 32'h0, valid: 1};
      apply(v, $sformatf("run%0d", i));
    end

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net if the main sequence stalls for any reason.
  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
